// File: rtl/delay_meas_ctrl.sv
// Gated edge-count frequency measurement sequencer for on-chip oscillators.
// Define DELAY_MEAS_AUTORUN_EN for back-to-back measurements without start.
module delay_meas_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         sel,
  input  logic               osc_in,
  output logic               osc_en,
  output logic [2:0]         osc_sel,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] result,
  output logic               overflow
);

  localparam int TMAX = (SETTLE_CYCLES > GATE_CYCLES) ?
                        SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t             state;
  logic               sync1;
  logic               sync2;
  logic               sync3;
  logic               rise;
  logic [TW-1:0]      timer;
  logic [COUNT_W-1:0] count;
  logic               sat;

  assign rise = sync2 & ~sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      count    <= '0;
      sat      <= 1'b0;
      osc_en   <= 1'b0;
      osc_sel  <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state   <= S_SETTLE;
            osc_sel <= sel;
            osc_en  <= 1'b1;
            busy    <= 1'b1;
            timer   <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state  <= S_IDLE;
            osc_en <= 1'b0;
            busy   <= 1'b0;
          end else if (timer == SET_LAST) begin
            state <= S_MEASURE;
            timer <= '0;
            count <= '0;
            sat   <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_MEASURE: begin
          if (abort) begin
            state  <= S_IDLE;
            osc_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            // an edge arriving at full scale is lost and flagged
            if (rise) begin
              if (count == CNT_MAX) sat <= 1'b1;
              else count <= count + 1'b1;
            end
            if (timer == GATE_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
`ifndef DELAY_MEAS_AUTORUN_EN
              osc_en <= 1'b0;
`endif
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_DONE: begin
          result   <= count;
          overflow <= sat;
          done     <= 1'b1;
`ifdef DELAY_MEAS_AUTORUN_EN
          state   <= S_SETTLE;
          osc_sel <= sel;
          osc_en  <= 1'b1;
          busy    <= 1'b1;
          timer   <= '0;
`else
          state <= S_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Scoreboard bench for delay_meas_ctrl (SETTLE=4, GATE=100).
// Saturation is exercised on a second instance with COUNT_W=4.
module tb_delay_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        osc_in = 1'b0;
  logic        osc_en;
  logic [2:0]  osc_sel;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  logic        start_s = 1'b0;
  logic        osc_s = 1'b0;
  logic        fast_on = 1'b0;
  logic        osc_en_s;
  logic [2:0]  osc_sel_s;
  logic        busy_s;
  logic        done_s;
  logic [3:0]  result_s;
  logic        overflow_s;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   osc_per = 4;
  int   ph = 0;

  always #5 clk = ~clk;

  delay_meas_ctrl #(
    .SETTLE_CYCLES(4), .GATE_CYCLES(100), .COUNT_W(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sel(sel), .osc_in(osc_in), .osc_en(osc_en),
    .osc_sel(osc_sel), .busy(busy), .done(done),
    .result(result), .overflow(overflow)
  );

  delay_meas_ctrl #(
    .SETTLE_CYCLES(4), .GATE_CYCLES(100), .COUNT_W(4)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0),
    .sel(3'd1), .osc_in(osc_s), .osc_en(osc_en_s),
    .osc_sel(osc_sel_s), .busy(busy_s), .done(done_s),
    .result(result_s), .overflow(overflow_s)
  );

  // clk-synchronous oscillator models
  always @(posedge clk) begin
    #1;
    if (osc_per == 0) begin
      osc_in = 1'b0;
    end else begin
      ph = (ph + 1) % osc_per;
      osc_in = (ph < osc_per / 2);
    end
    osc_s = fast_on ? ~osc_s : 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done result=%0d required=no_done", result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || overflow !== mon_e.ovf) begin
          miscompares++;
          $display("FAIL sb_result got=%0d/%0b want=%0d/%0b",
                   result, overflow, mon_e.res, mon_e.ovf);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_osc_en", int'(osc_en), 0);
    chk("rst_osc_sel", int'(osc_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_overflow", int'(overflow), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_measure(input string nm, input logic [2:0] s,
                             input logic [15:0] er);
    int busy_n;
    int done_n;
    int done_at;
    sb.push_back('{er, 1'b0});
    sel = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sel = ~s;
    busy_n = 0;
    done_n = 0;
    done_at = -1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk({nm, "_osc_sel"}, int'(osc_sel), int'(s));
        chk({nm, "_osc_en"}, int'(osc_en), 1);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
    end
    chk({nm, "_busy_cycles"}, busy_n, 104);
    chk({nm, "_done_count"}, done_n, 1);
    chk({nm, "_done_at"}, done_at, 105);
    chk({nm, "_osc_en_off"}, int'(osc_en), 0);
    chk({nm, "_result"}, int'(result), int'(er));
  endtask

  task automatic test_basic();
    osc_per = 4;
    run_measure("basic", 3'd5, 16'd25);
  endtask

  task automatic sat_run(input string nm, input int er, input int eo);
    int seen;
    seen = 0;
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (done_s) seen = 1;
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_result"}, int'(result_s), er);
    chk({nm, "_overflow"}, int'(overflow_s), eo);
  endtask

  task automatic test_saturate();
    fast_on = 1'b1;
    sat_run("sat_fast", 15, 1);
    fast_on = 1'b0;
    sat_run("sat_static", 0, 0);
  endtask

  task automatic test_abort();
    int done_n;
    done_n = 0;
    sel = 3'd6;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) done_n++;
      if (i == 53) abort = 1'b1;
      if (i == 54) begin
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_osc_en", int'(osc_en), 0);
      end
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_result_kept", int'(result), 25);
    run_measure("after_abort", 3'd2, 16'd25);
  endtask

  task automatic test_start_held();
    int done_n;
    done_n = 0;
    sb.push_back('{16'd25, 1'b0});
    sel = 3'd5;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      if (done) done_n++;
      if (i == 50) sel = 3'd2;
      if (i == 60) chk("held_osc_sel", int'(osc_sel), 5);
      if (i == 100) start = 1'b0;
    end
    chk("held_done_count", done_n, 1);
    chk("held_idle_busy", int'(busy), 0);
  endtask

  task automatic test_abort_start_idle();
    int busy_n;
    busy_n = 0;
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || osc_en) busy_n++;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_idle", busy_n, 0);
  endtask

  task automatic test_reset_mid();
    sel = 3'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (60) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_osc_en", int'(osc_en), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_osc_sel", int'(osc_sel), 0);
    chk("rstmid_result", int'(result), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_measure("after_reset", 3'd1, 16'd25);
  endtask

  task automatic test_autorun();
    int done_n;
    int last;
    done_n = 0;
    last = -1;
    for (int k = 0; k < 3; k++) sb.push_back('{16'd25, 1'b0});
    osc_per = 4;
    sel = 3'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (last < 0) chk("auto_first_done", i, 105);
        else chk("auto_interval", i - last, 105);
        last = i;
      end
      if (i == 320) abort = 1'b1;
      if (i == 321) begin
        abort = 1'b0;
        chk("auto_abort_busy", int'(busy), 0);
      end
    end
    chk("auto_done_count", done_n, 3);
  endtask

  initial begin
    test_reset();
`ifdef DELAY_MEAS_AUTORUN_EN
    test_autorun();
`else
    test_basic();
    test_saturate();
    test_start_held();
    test_abort();
    test_abort_start_idle();
    test_reset_mid();
`endif
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
